// File: rtl/fpu_dispatch_queue.sv
// In-order request FIFO feeding NUM_UNITS FPU units; doorbell->unit_start 2 cycles, result held until result_ack.
// Backpressure: fpu_doorbell_r drops when the FIFO is full; doorbells while full are dropped and flagged sticky.
module fpu_dispatch_queue #(
  parameter int WIDTH     = 32,
  parameter int NUM_UNITS = 12,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fpu_rst_w,
  input  logic                       fpu_doorbell_w,
  input  logic [$clog2(NUM_UNITS)-1:0] unit_sel,
  input  logic [WIDTH-1:0]           fpu_operand_a,
  input  logic [WIDTH-1:0]           fpu_operand_b,
  input  logic [WIDTH-1:0]           fpu_operand_c,
  output logic                       fpu_doorbell_r,
  output logic [NUM_UNITS-1:0]       unit_start,
  output logic [WIDTH-1:0]           unit_operand_a,
  output logic [WIDTH-1:0]           unit_operand_b,
  output logic [WIDTH-1:0]           unit_operand_c,
  input  logic [NUM_UNITS-1:0]       unit_done,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_result,
  input  logic [NUM_UNITS*4-1:0]     unit_flags,
  input  logic                       result_ack,
  input  logic                       fpu_int_en,
  output logic [WIDTH-1:0]           fpu_output,
  output logic [3:0]                 fpu_flags,
  output logic                       fpu_ready,
  output logic                       fpu_interrupt_w,
  output logic                       overflow_err,
  output logic                       busy
);
  localparam int UNIT_W = $clog2(NUM_UNITS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int PAD_N  = 1 << UNIT_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t             state;
  logic [UNIT_W-1:0]  fifo_sel [DEPTH];
  logic [WIDTH-1:0]   fifo_a   [DEPTH];
  logic [WIDTH-1:0]   fifo_b   [DEPTH];
  logic [WIDTH-1:0]   fifo_c   [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic [UNIT_W-1:0]  issue_sel;
  logic [CNT_W-1:0]   wait_cnt;
  logic               hold_first;
  logic               full, push, pop, sel_done;
  logic [NUM_UNITS-1:0] start_vec;

  // Zero-padded views so an out-of-range select reads as "no done".
  logic [PAD_N-1:0]       done_pad;
  logic [PAD_N*WIDTH-1:0] result_pad;
  logic [PAD_N*4-1:0]     flags_pad;

  assign done_pad   = PAD_N'(unit_done);
  assign result_pad = (PAD_N*WIDTH)'(unit_result);
  assign flags_pad  = (PAD_N*4)'(unit_flags);

  assign full           = (count == (PTR_W+1)'(DEPTH));
  assign push           = fpu_doorbell_w && !full;
  assign pop            = (state == IDLE) && (count != '0);
  assign fpu_doorbell_r = !full;
  assign busy           = (state != IDLE) || (count != '0);
  assign fpu_ready      = (state == HOLD);
  assign fpu_interrupt_w = hold_first && fpu_int_en;
  assign sel_done       = done_pad[issue_sel];
  // Shifting past the top bit yields zero, so invalid selects never start a unit.
  assign start_vec      = NUM_UNITS'(1) << fifo_sel[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_sel[wr_ptr] <= unit_sel;
      fifo_a[wr_ptr]   <= fpu_operand_a;
      fifo_b[wr_ptr]   <= fpu_operand_b;
      fifo_c[wr_ptr]   <= fpu_operand_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || fpu_rst_w) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      issue_sel      <= '0;
      unit_operand_a <= '0;
      unit_operand_b <= '0;
      unit_operand_c <= '0;
      unit_start     <= '0;
      wait_cnt       <= '0;
      fpu_output     <= '0;
      fpu_flags      <= '0;
      hold_first     <= 1'b0;
      overflow_err   <= 1'b0;
    end else begin
      unit_start <= '0;
      hold_first <= 1'b0;
      if (fpu_doorbell_w && full) overflow_err <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      case (state)
        IDLE: if (pop) begin
          issue_sel      <= fifo_sel[rd_ptr];
          unit_operand_a <= fifo_a[rd_ptr];
          unit_operand_b <= fifo_b[rd_ptr];
          unit_operand_c <= fifo_c[rd_ptr];
          unit_start     <= start_vec;
          state          <= ISSUE;
        end
        ISSUE: begin
          wait_cnt <= '0;
          if (unit_start != '0) begin
            state <= WAIT;
          end else begin
            fpu_output <= '0;
            fpu_flags  <= 4'b1000;
            hold_first <= 1'b1;
            state      <= HOLD;
          end
        end
        WAIT: begin
          if (sel_done) begin
            fpu_output <= result_pad[issue_sel*WIDTH +: WIDTH];
            fpu_flags  <= flags_pad[issue_sel*4 +: 4];
            hold_first <= 1'b1;
            state      <= HOLD;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            fpu_output <= '0;
            fpu_flags  <= 4'b1000;
            hold_first <= 1'b1;
            state      <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: if (result_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_dispatch_queue.sv
// Bench for fpu_dispatch_queue: scenario tasks against a queue-based model of pending requests.
module tb_fpu_dispatch_queue;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         fpu_rst_w = 1'b0;
  logic         fpu_doorbell_w = 1'b0;
  logic [3:0]   unit_sel = '0;
  logic [31:0]  fpu_operand_a = '0, fpu_operand_b = '0, fpu_operand_c = '0;
  logic         fpu_doorbell_r;
  logic [11:0]  unit_start;
  logic [31:0]  unit_operand_a, unit_operand_b, unit_operand_c;
  logic [11:0]  unit_done = '0;
  logic [383:0] unit_result = '0;
  logic [47:0]  unit_flags = '0;
  logic         result_ack = 1'b0;
  logic         fpu_int_en = 1'b0;
  logic [31:0]  fpu_output;
  logic [3:0]   fpu_flags;
  logic         fpu_ready, fpu_interrupt_w, overflow_err, busy;

  int total = 0;
  int bad = 0;

  logic [3:0]  q_sel[$];
  logic [31:0] q_a[$], q_b[$], q_c[$];

  fpu_dispatch_queue dut (
    .clk(clk), .reset(reset), .fpu_rst_w(fpu_rst_w), .fpu_doorbell_w(fpu_doorbell_w),
    .unit_sel(unit_sel), .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b),
    .fpu_operand_c(fpu_operand_c), .fpu_doorbell_r(fpu_doorbell_r), .unit_start(unit_start),
    .unit_operand_a(unit_operand_a), .unit_operand_b(unit_operand_b), .unit_operand_c(unit_operand_c),
    .unit_done(unit_done), .unit_result(unit_result), .unit_flags(unit_flags),
    .result_ack(result_ack), .fpu_int_en(fpu_int_en), .fpu_output(fpu_output),
    .fpu_flags(fpu_flags), .fpu_ready(fpu_ready), .fpu_interrupt_w(fpu_interrupt_w),
    .overflow_err(overflow_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_result(input logic [3:0] s, input logic [31:0] r, input logic [3:0] f);
    for (int i = 0; i < 12; i++) unit_result[i*32 +: 32] = $urandom;
    unit_flags = {$urandom, $urandom};
    unit_result[s*32 +: 32] = r;
    unit_flags[s*4 +: 4] = f;
  endtask

  task automatic drive_doorbell(input logic [3:0] s, input logic [31:0] a, b, c);
    fpu_doorbell_w = 1'b1; unit_sel = s;
    fpu_operand_a = a; fpu_operand_b = b; fpu_operand_c = c;
    step();
    fpu_doorbell_w = 1'b0;
  endtask

  task automatic push_req(input logic [3:0] s);
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    q_sel.push_back(s); q_a.push_back(a); q_b.push_back(b); q_c.push_back(c);
    drive_doorbell(s, a, b, c);
  endtask

  // Serves the oldest modelled request: acts as the unit, checks result, acks.
  task automatic serve_head();
    logic [3:0] s, f;
    logic [31:0] ea, eb, ec, r;
    logic [11:0] m;
    logic ie;
    bit seen;
    int n, d;
    s = q_sel.pop_front(); ea = q_a.pop_front(); eb = q_b.pop_front(); ec = q_c.pop_front();
    ie = 1'($urandom_range(0, 1));
    fpu_int_en = ie;
    r = '0; f = 4'b1000; seen = 0; n = 0;
    m = (s < 12) ? (12'h001 << s) : 12'h000;
    while (fpu_ready !== 1'b1 && n < 40) begin
      if (unit_start !== 12'h000) begin
        seen = 1;
        total++; if (unit_start !== m) begin bad++; $display("FAIL serve_start: got %h want %h", unit_start, m); end
        total++; if ({unit_operand_a, unit_operand_b, unit_operand_c} !== {ea, eb, ec}) begin
          bad++; $display("FAIL serve_operands: got %h %h %h want %h %h %h", unit_operand_a, unit_operand_b, unit_operand_c, ea, eb, ec); end
        step();
        d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin
          unit_done = 12'($urandom) & ~m;
          step();
        end
        r = $urandom; f = 4'($urandom);
        set_result(s, r, f);
        unit_done = m;
        total++; if (unit_operand_a !== ea) begin bad++; $display("FAIL serve_opa_stable: got %h want %h", unit_operand_a, ea); end
        step();
        unit_done = '0;
      end else begin
        step();
      end
      n++;
    end
    total++; if (fpu_ready !== 1'b1) begin bad++; $display("FAIL serve_ready: got %b want 1", fpu_ready); end
    total++; if (seen !== (s < 12)) begin bad++; $display("FAIL serve_start_seen: got %b want %b sel=%0d", seen, (s < 12), s); end
    total++; if (fpu_output !== r) begin bad++; $display("FAIL serve_output: got %h want %h", fpu_output, r); end
    total++; if (fpu_flags !== f) begin bad++; $display("FAIL serve_flags: got %h want %h", fpu_flags, f); end
    total++; if (fpu_interrupt_w !== ie) begin bad++; $display("FAIL serve_interrupt: got %b want %b", fpu_interrupt_w, ie); end
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    total++; if (fpu_ready !== 1'b0) begin bad++; $display("FAIL serve_ack: got %b want 0", fpu_ready); end
  endtask

  task automatic test_reset();
    total++; if ({fpu_doorbell_r, fpu_ready, busy, overflow_err, fpu_interrupt_w} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 10000", {fpu_doorbell_r, fpu_ready, busy, overflow_err, fpu_interrupt_w}); end
    total++; if ({unit_start, fpu_output, fpu_flags, unit_operand_a} !== '0) begin
      bad++; $display("FAIL reset_data: got %h %h %h %h want 0", unit_start, fpu_output, fpu_flags, unit_operand_a); end
  endtask

  task automatic test_basic();
    fpu_int_en = 1'b1;
    drive_doorbell(4'd9, 32'h12, 32'h34, 32'h0);
    total++; if (unit_start !== 12'h000) begin bad++; $display("FAIL basic_c1_start: got %h want 000", unit_start); end
    step();
    total++; if (unit_start !== 12'h200) begin bad++; $display("FAIL basic_c2_start: got %h want 200", unit_start); end
    total++; if ({unit_operand_a, unit_operand_b} !== {32'h12, 32'h34}) begin
      bad++; $display("FAIL basic_operands: got %h %h want 12 34", unit_operand_a, unit_operand_b); end
    step();
    total++; if ({unit_start, fpu_ready} !== 13'h0) begin bad++; $display("FAIL basic_c3: got %h %b want 0 0", unit_start, fpu_ready); end
    set_result(4'd9, 32'h46, 4'h0);
    unit_done = 12'h200;
    step();
    unit_done = '0;
    total++; if (fpu_ready !== 1'b1) begin bad++; $display("FAIL basic_c4_ready: got %b want 1", fpu_ready); end
    total++; if ({fpu_output, fpu_flags} !== {32'h46, 4'h0}) begin bad++; $display("FAIL basic_out: got %h %h want 46 0", fpu_output, fpu_flags); end
    total++; if (fpu_interrupt_w !== 1'b1) begin bad++; $display("FAIL basic_int: got %b want 1", fpu_interrupt_w); end
    step();
    total++; if ({fpu_interrupt_w, fpu_ready} !== 2'b01) begin bad++; $display("FAIL basic_hold: got %b want 01", {fpu_interrupt_w, fpu_ready}); end
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    total++; if ({fpu_ready, busy} !== 2'b00) begin bad++; $display("FAIL basic_ack: got %b want 00", {fpu_ready, busy}); end
  endtask

  task automatic test_random_stream();
    for (int k = 0; k < 5; k++) begin
      push_req(4'($urandom_range(0, 13)));
      push_req(4'($urandom_range(0, 11)));
      serve_head();
      serve_head();
    end
  endtask

  task automatic test_fill();
    push_req(4'd12);
    repeat (4) step();
    total++; if (fpu_ready !== 1'b1) begin bad++; $display("FAIL fill_hold: got %b want 1", fpu_ready); end
    for (int k = 0; k < 4; k++) begin
      total++; if (fpu_doorbell_r !== 1'b1) begin bad++; $display("FAIL fill_room_%0d: got %b want 1", k, fpu_doorbell_r); end
      push_req(4'($urandom_range(0, 11)));
    end
    total++; if (fpu_doorbell_r !== 1'b0) begin bad++; $display("FAIL fill_full: got %b want 0", fpu_doorbell_r); end
    drive_doorbell(4'd1, 32'hBAD, 32'hBAD, 32'hBAD);
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL fill_overflow: got %b want 1", overflow_err); end
    void'(q_sel.pop_front()); void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_c.pop_front());
    total++; if ({fpu_output, fpu_flags} !== {32'h0, 4'b1000}) begin bad++; $display("FAIL fill_first: got %h %h want 0 8", fpu_output, fpu_flags); end
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    for (int k = 0; k < 4; k++) serve_head();
    total++; if ({overflow_err, fpu_doorbell_r, busy} !== 3'b110) begin
      bad++; $display("FAIL fill_after: got %b want 110", {overflow_err, fpu_doorbell_r, busy}); end
  endtask

  task automatic test_timeout();
    logic ie;
    int n;
    ie = 1'($urandom_range(0, 1));
    fpu_int_en = ie;
    drive_doorbell(4'd3, $urandom, $urandom, $urandom);
    step();
    total++; if (unit_start !== 12'h008) begin bad++; $display("FAIL to_start: got %h want 008", unit_start); end
    n = 0;
    while (fpu_ready !== 1'b1 && n < 400) begin step(); n++; end
    total++; if (n !== 256) begin bad++; $display("FAIL to_latency: got %0d want 256", n); end
    total++; if ({fpu_output, fpu_flags} !== {32'h0, 4'b1000}) begin bad++; $display("FAIL to_out: got %h %h want 0 8", fpu_output, fpu_flags); end
    total++; if (fpu_interrupt_w !== ie) begin bad++; $display("FAIL to_int: got %b want %b", fpu_interrupt_w, ie); end
    set_result(4'd3, 32'hDEAD, 4'h1);
    unit_done = 12'h008;
    step();
    unit_done = '0;
    total++; if ({fpu_ready, fpu_output, fpu_flags} !== {1'b1, 32'h0, 4'b1000}) begin
      bad++; $display("FAIL to_late_done: got %b %h %h want 1 0 8", fpu_ready, fpu_output, fpu_flags); end
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    unit_done = 12'h008;
    repeat (3) step();
    unit_done = '0;
    total++; if ({fpu_ready, busy, unit_start} !== 14'h0) begin bad++; $display("FAIL to_idle: got %b %b %h want 0 0 0", fpu_ready, busy, unit_start); end
  endtask

  task automatic test_invalid_sel();
    int starts, ints;
    bit got_ready;
    starts = 0; ints = 0; got_ready = 0;
    fpu_int_en = 1'b1;
    drive_doorbell(4'd13, $urandom, $urandom, $urandom);
    for (int k = 0; k < 10; k++) begin
      if (unit_start !== 12'h000) starts++;
      if (fpu_interrupt_w === 1'b1) ints++;
      if (fpu_ready === 1'b1) got_ready = 1;
      step();
    end
    total++; if (starts !== 0) begin bad++; $display("FAIL inv_starts: got %0d want 0", starts); end
    total++; if (ints !== 1) begin bad++; $display("FAIL inv_ints: got %0d want 1", ints); end
    total++; if (got_ready !== 1'b1) begin bad++; $display("FAIL inv_ready: got %b want 1", got_ready); end
    total++; if ({fpu_output, fpu_flags} !== {32'h0, 4'b1000}) begin bad++; $display("FAIL inv_out: got %h %h want 0 8", fpu_output, fpu_flags); end
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
  endtask

  task automatic test_flush();
    drive_doorbell(4'd5, $urandom, $urandom, $urandom);
    step();
    total++; if (unit_start !== 12'h020) begin bad++; $display("FAIL flush_start: got %h want 020", unit_start); end
    step();
    drive_doorbell(4'd1, $urandom, $urandom, $urandom);
    drive_doorbell(4'd2, $urandom, $urandom, $urandom);
    fpu_rst_w = 1'b1;
    set_result(4'd5, 32'h1234, 4'h2);
    unit_done = 12'h020;
    step();
    fpu_rst_w = 1'b0;
    total++; if ({fpu_ready, fpu_doorbell_r, busy, overflow_err} !== 4'b0100) begin
      bad++; $display("FAIL flush_state: got %b want 0100", {fpu_ready, fpu_doorbell_r, busy, overflow_err}); end
    step();
    unit_done = '0;
    repeat (3) step();
    total++; if ({fpu_ready, busy, unit_start} !== 14'h0) begin bad++; $display("FAIL flush_quiet: got %b %b %h want 0 0 0", fpu_ready, busy, unit_start); end
  endtask

  task automatic test_back_to_back_wrap();
    push_req(4'($urandom_range(0, 11)));
    push_req(4'($urandom_range(0, 11)));
    for (int i = 0; i < 8; i++) begin
      serve_head();
      if (i < 6) push_req(4'($urandom_range(0, 11)));
    end
    total++; if ({overflow_err, fpu_doorbell_r, busy} !== 3'b010) begin
      bad++; $display("FAIL wrap_end: got %b want 010", {overflow_err, fpu_doorbell_r, busy}); end
    total++; if (q_sel.size() !== 0) begin bad++; $display("FAIL wrap_model_left: got %0d want 0", q_sel.size()); end
  endtask

  initial begin
    step();
    step();
    test_reset();
    reset = 1'b0;
    step();
    test_basic();
    test_random_stream();
    test_fill();
    test_timeout();
    test_invalid_sel();
    test_flush();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
